// File: rtl/wall_multi_ctrl_if.sv
// ---------------------------------------------------------------------------
// wall_multi_ctrl_if
//   Connects the game controller to the input/collision logic (go, touched)
//   and to the VGA draw datapath (status, tick, wall positions, score).
//   master : the environment that drives go/touched and consumes the outputs
//   slave  : the wall_multi_ctrl block
// Signals
//   go          level, start game from READY; must drop to leave STOP
//   touched     level, collision detected
//   start/move/stopped  one-hot game state decode
//   tick        1-cycle move tick pulse while in MOVE
//   wall_active bit i = wall i on screen
//   wall_x      wall i x at [i*X_W +: X_W]
//   score       walls retired since game start, saturating
// ---------------------------------------------------------------------------
interface wall_multi_ctrl_if #(
   parameter int NUM_WALLS = 4,
   parameter int X_W       = 8
);
   logic                       go;
   logic                       touched;
   logic                       start;
   logic                       move;
   logic                       stopped;
   logic                       tick;
   logic [NUM_WALLS-1:0]       wall_active;
   logic [NUM_WALLS*X_W-1:0]   wall_x;
   logic [7:0]                 score;

   modport master (
      output go, touched,
      input  start, move, stopped, tick, wall_active, wall_x, score
   );

   modport slave (
      input  go, touched,
      output start, move, stopped, tick, wall_active, wall_x, score
   );
endinterface

// File: rtl/wall_multi_ctrl.sv
// ---------------------------------------------------------------------------
// wall_multi_ctrl
//   Global READY/MOVE/STOP game FSM driving NUM_WALLS wall channels. Walls
//   spawn at X_START on a spawn timer counted in move ticks, step left by STEP
//   on each move tick, and retire (counted as score) when another step would
//   pass X_END.
// Ports
//   clk     system clock, rising edge
//   resetn  synchronous reset, active low
//   bus     wall_multi_ctrl_if.slave (go/touched in; state, tick, walls,
//           score out)
// ---------------------------------------------------------------------------
module wall_multi_ctrl #(
   parameter int NUM_WALLS = 4,
   parameter int X_W       = 8,
   parameter int X_START   = 159,
   parameter int X_END     = 0,
   parameter int STEP      = 1,
   parameter int TICK_DIV  = 833333,
   parameter int SPAWN_GAP = 40
) (
   input logic                clk,
   input logic                resetn,
   wall_multi_ctrl_if.slave   bus
);

   localparam logic [1:0] S_READY = 2'd0;
   localparam logic [1:0] S_MOVE  = 2'd1;
   localparam logic [1:0] S_STOP  = 2'd2;

   localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SPAWN_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam int CNT_W   = $clog2(NUM_WALLS + 1);
   localparam int SUM_W   = 8 + CNT_W;
   localparam int XL_W    = X_W + 1;

   localparam logic [TICK_W-1:0]  TICK_LAST    = TICK_W'(TICK_DIV - 1);
   localparam logic [SPAWN_W-1:0] SPAWN_RELOAD = SPAWN_W'(SPAWN_GAP - 1);
   localparam logic [X_W-1:0]     X_START_V    = X_W'(X_START);
   localparam logic [X_W-1:0]     STEP_V       = X_W'(STEP);
   // One bit wider so X_END+STEP never wraps in the retire compare.
   localparam logic [XL_W-1:0]    RETIRE_LIM   = XL_W'(X_END + STEP);

   logic [1:0]            r_state;
   logic [TICK_W-1:0]     r_tick_cnt;
   logic [SPAWN_W-1:0]    r_spawn_cnt;
   logic [NUM_WALLS-1:0]  r_active;
   logic [X_W-1:0]        r_x [NUM_WALLS];
   logic [7:0]            r_score;

   logic                  w_tick;
   logic [NUM_WALLS-1:0]  w_retire;
   logic [NUM_WALLS-1:0]  w_spawn_sel;
   logic [CNT_W-1:0]      w_retire_cnt;
   logic [SUM_W-1:0]      w_score_sum;
   logic [7:0]            w_score_next;
   logic                  w_found;
   logic [NUM_WALLS*X_W-1:0] w_wall_x;

   assign w_tick = (r_state == S_MOVE) && (r_tick_cnt == TICK_LAST);

   // Retire flags, retire count and the single spawn target. The spawn slot
   // is chosen from walls inactive at the start of the tick, so a wall that
   // retires on this tick cannot be reused until the next one.
   always_comb begin
      w_retire     = '0;
      w_spawn_sel  = '0;
      w_retire_cnt = '0;
      w_found      = 1'b0;
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
         w_retire[i]  = r_active[i] && ({1'b0, r_x[i]} < RETIRE_LIM);
         w_retire_cnt = w_retire_cnt + CNT_W'(w_retire[i]);
         if (!r_active[i] && !w_found && (r_spawn_cnt == '0)) begin
            w_spawn_sel[i] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

   always_comb begin
      w_score_sum = SUM_W'(r_score) + SUM_W'(w_retire_cnt);
      if (w_score_sum > SUM_W'(255)) begin
         w_score_next = 8'hFF;
      end else begin
         w_score_next = w_score_sum[7:0];
      end
   end

   always_comb begin
      w_wall_x = '0;
      for (int unsigned i = 0; i < NUM_WALLS; i++) begin
         w_wall_x[i*X_W +: X_W] = r_x[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_READY;
         r_tick_cnt  <= '0;
         r_spawn_cnt <= '0;
         r_active    <= '0;
         r_score     <= '0;
         for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            r_x[i] <= X_START_V;
         end
      end else begin
         case (r_state)
            S_READY: begin
               if (bus.go) begin
                  r_state     <= S_MOVE;
                  r_tick_cnt  <= '0;
                  r_spawn_cnt <= '0;
                  r_active    <= '0;
                  r_score     <= '0;
                  for (int unsigned i = 0; i < NUM_WALLS; i++) begin
                     r_x[i] <= X_START_V;
                  end
               end
            end
            S_MOVE: begin
               if (bus.touched) begin
                  // Collision wins over a coincident tick: walls freeze as-is.
                  r_state    <= S_STOP;
                  r_tick_cnt <= '0;
               end else begin
                  r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
                  if (w_tick) begin
                     r_score     <= w_score_next;
                     r_spawn_cnt <= (r_spawn_cnt == '0) ? SPAWN_RELOAD
                                                        : r_spawn_cnt - SPAWN_W'(1);
                     for (int unsigned i = 0; i < NUM_WALLS; i++) begin
                        if (w_retire[i]) begin
                           r_active[i] <= 1'b0;
                           r_x[i]      <= X_START_V;
                        end else if (r_active[i]) begin
                           r_x[i] <= r_x[i] - STEP_V;
                        end else if (w_spawn_sel[i]) begin
                           r_active[i] <= 1'b1;
                           r_x[i]      <= X_START_V;
                        end
                     end
                  end
               end
            end
            S_STOP: begin
               if (!bus.go) begin
                  r_state <= S_READY;
               end
            end
            default: begin
               r_state <= S_READY;
            end
         endcase
      end
   end

   assign bus.start       = (r_state == S_READY);
   assign bus.move        = (r_state == S_MOVE);
   assign bus.stopped     = (r_state == S_STOP);
   assign bus.tick        = w_tick;
   assign bus.wall_active = r_active;
   assign bus.wall_x      = w_wall_x;
   assign bus.score       = r_score;

endmodule

// File: tb/tb_wall_multi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wall_multi_ctrl
//   Directed bench for wall_multi_ctrl. Three instances share one clock:
//   main (2 walls, STEP=3, SPAWN_GAP=3), gap (SPAWN_GAP=1, STEP=1) and sat
//   (32 walls, X_START=255, STEP=1, TICK_DIV=2) for score saturation.
// ---------------------------------------------------------------------------
module tb_wall_multi_ctrl;

   logic clk;
   logic resetn;

   int errs   = 0;
   int checks = 0;

   wall_multi_ctrl_if #(.NUM_WALLS(2),  .X_W(8)) if_m ();
   wall_multi_ctrl_if #(.NUM_WALLS(2),  .X_W(8)) if_g ();
   wall_multi_ctrl_if #(.NUM_WALLS(32), .X_W(8)) if_s ();

   wall_multi_ctrl #(
      .NUM_WALLS(2), .X_W(8), .X_START(10), .X_END(0), .STEP(3),
      .TICK_DIV(4), .SPAWN_GAP(3)
   ) dut_m (.clk(clk), .resetn(resetn), .bus(if_m.slave));

   wall_multi_ctrl #(
      .NUM_WALLS(2), .X_W(8), .X_START(10), .X_END(0), .STEP(1),
      .TICK_DIV(4), .SPAWN_GAP(1)
   ) dut_g (.clk(clk), .resetn(resetn), .bus(if_g.slave));

   wall_multi_ctrl #(
      .NUM_WALLS(32), .X_W(8), .X_START(255), .X_END(0), .STEP(1),
      .TICK_DIV(2), .SPAWN_GAP(1)
   ) dut_s (.clk(clk), .resetn(resetn), .bus(if_s.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-derived per-tick results for the main instance, ticks 1..19:
   // {wall_active, x0, x1, score}
   int exp_act [1:19] = '{1,1,1,3,2,2,3,1,1,3,2,2,3,1,1,3,2,2,3};
   int exp_x0  [1:19] = '{10,7,4,1,10,10,10,7,4,1,10,10,10,7,4,1,10,10,10};
   int exp_x1  [1:19] = '{10,10,10,10,7,4,1,10,10,10,7,4,1,10,10,10,7,4,1};
   int exp_sc  [1:19] = '{0,0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5};

   // Gap instance, ticks 1..4
   int g_act [1:4] = '{1,3,3,3};
   int g_x0  [1:4] = '{10,9,8,7};
   int g_x1  [1:4] = '{10,10,9,8};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance until the selected instance shows a tick, then through the edge
   // that applies it.
   task automatic next_tick(input int which);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step(1);
         seen = (which == 0) ? if_m.tick : if_g.tick;
      end
      check($sformatf("tick_seen_%0d", which), 32'(seen), 32'd1);
      step(1);
   endtask

   task automatic check_row(input int t);
      check($sformatf("t%0d_active", t), 32'(if_m.wall_active), 32'(exp_act[t]));
      check($sformatf("t%0d_x0", t),     32'(if_m.wall_x[7:0]),  32'(exp_x0[t]));
      check($sformatf("t%0d_x1", t),     32'(if_m.wall_x[15:8]), 32'(exp_x1[t]));
      check($sformatf("t%0d_score", t),  32'(if_m.score),        32'(exp_sc[t]));
   endtask

   task automatic check_reset_m(input string tag);
      check({tag, "_start"},   32'(if_m.start),        32'd1);
      check({tag, "_move"},    32'(if_m.move),         32'd0);
      check({tag, "_stopped"}, 32'(if_m.stopped),      32'd0);
      check({tag, "_tick"},    32'(if_m.tick),         32'd0);
      check({tag, "_active"},  32'(if_m.wall_active),  32'd0);
      check({tag, "_x0"},      32'(if_m.wall_x[7:0]),  32'd10);
      check({tag, "_x1"},      32'(if_m.wall_x[15:8]), 32'd10);
      check({tag, "_score"},   32'(if_m.score),        32'd0);
   endtask

   initial begin
      logic seen;
      logic [7:0] prev;

      resetn = 1'b0;
      if_m.go = 1'b0; if_m.touched = 1'b0;
      if_g.go = 1'b0; if_g.touched = 1'b0;
      if_s.go = 1'b0; if_s.touched = 1'b0;
      step(2);
      check_reset_m("rst0");
      check("rst0_g_active", 32'(if_g.wall_active), 32'd0);
      check("rst0_s_score",  32'(if_s.score),       32'd0);
      resetn = 1'b1;
      step(1);

      // Start: MOVE next cycle, first tick on the 4th MOVE cycle
      if_m.go = 1'b1;
      step(1);
      check("go_move", 32'(if_m.move), 32'd1);
      check("go_tick_c1", 32'(if_m.tick), 32'd0);
      step(2);
      check("go_tick_c3", 32'(if_m.tick), 32'd0);
      step(1);
      check("first_tick_c4", 32'(if_m.tick), 32'd1);
      step(1);
      check_row(1);
      for (int t = 2; t <= 19; t++) begin
         next_tick(0);
         check_row(t);
      end

      // Collision coincident with tick 20: freeze
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step(1);
         seen = if_m.tick;
      end
      check("touch_tick_seen", 32'(seen), 32'd1);
      if_m.touched = 1'b1;
      step(1);
      check("touch_stopped", 32'(if_m.stopped), 32'd1);
      check("touch_move",    32'(if_m.move),    32'd0);
      check("touch_active",  32'(if_m.wall_active), 32'd3);
      check("touch_x0",      32'(if_m.wall_x[7:0]),  32'd10);
      check("touch_x1",      32'(if_m.wall_x[15:8]), 32'd1);
      check("touch_score",   32'(if_m.score), 32'd5);
      step(3);
      check("stop_go_held", 32'(if_m.stopped), 32'd1);
      check("stop_hold_x1", 32'(if_m.wall_x[15:8]), 32'd1);
      if_m.touched = 1'b0;
      if_m.go = 1'b0;
      step(1);
      check("stop_to_ready", 32'(if_m.start), 32'd1);
      check("ready_score_held", 32'(if_m.score), 32'd5);
      if_m.go = 1'b1;
      step(1);
      check("restart_move",   32'(if_m.move), 32'd1);
      check("restart_active", 32'(if_m.wall_active), 32'd0);
      check("restart_score",  32'(if_m.score), 32'd0);
      check("restart_x1",     32'(if_m.wall_x[15:8]), 32'd10);
      for (int t = 1; t <= 19; t++) begin
         next_tick(0);
         check_row(t);
      end

      // Reset mid-MOVE with both walls active and score 5
      resetn = 1'b0;
      if_m.go = 1'b0;
      step(1);
      check_reset_m("rst1");
      resetn = 1'b1;
      step(1);

      // Single-gap spawning: no free slot on tick 3
      if_g.go = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         next_tick(1);
         check($sformatf("g%0d_active", t), 32'(if_g.wall_active), 32'(g_act[t]));
         check($sformatf("g%0d_x0", t),     32'(if_g.wall_x[7:0]),  32'(g_x0[t]));
         check($sformatf("g%0d_x1", t),     32'(if_g.wall_x[15:8]), 32'(g_x1[t]));
         check($sformatf("g%0d_score", t),  32'(if_g.score),        32'd0);
      end

      // Saturation: several hundred retires, score must clamp at 255
      if_s.go = 1'b1;
      prev = 8'd0;
      for (int k = 0; k < 10; k++) begin
         step(1000);
         check($sformatf("sat_mono_%0d", k), 32'(if_s.score >= prev), 32'd1);
         prev = if_s.score;
      end
      check("sat_score", 32'(if_s.score), 32'd255);
      check("sat_move",  32'(if_s.move),  32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
